// File: rtl/sll_seq_shifter.sv
// -----------------------------------------------------------------------------
// sll_seq_shifter
//
// Sequential logical left shifter. An accepted operand is shifted by one
// binary-weighted stage per clock (stage k shifts by 2**k when amount bit k is
// set). The result therefore appears a fixed SHW cycles after the accept,
// whatever the shift amount. The result is held in DONE until the consumer
// takes it. WIDTH must equal 2**SHW.
//
// Ports
//   clk           in   clock, all state updates on the rising edge
//   rst           in   synchronous active-high reset
//   in_valid      in   request present
//   in_ready      out  block can accept a request (IDLE only)
//   data_in       in   [WIDTH-1:0] operand to shift
//   shift_amount  in   [SHW-1:0] left-shift distance
//   out_valid     out  result present (DONE only)
//   out_ready     in   consumer accepts the result
//   data_out      out  [WIDTH-1:0] working register (the result in DONE)
//   busy          out  high in any state other than IDLE
// -----------------------------------------------------------------------------
module sll_seq_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shift_amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             busy
);

  // Stage counter only needs to count 0..SHW-1.
  localparam int               STW       = (SHW > 1) ? $clog2(SHW) : 1;
  localparam logic [STW-1:0]   LAST_STAGE = STW'(SHW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [SHW-1:0]   amt_q,   amt_d;
  logic [STW-1:0]   stage_q, stage_d;

  // NOTE: every combinational output gets a default before the case
  // statement, so no path can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    amt_d   = amt_q;
    stage_d = stage_q;

    unique case (state_q)
      IDLE: begin
        // in_ready is 1 in IDLE, so in_valid alone signals an accept.
        if (in_valid) begin
          work_d  = data_in;
          amt_d   = shift_amount;
          stage_d = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        // Each stage has a constant shift distance; selecting it by comparing
        // against the counter keeps the datapath a simple mux of fixed shifts.
        for (int k = 0; k < SHW; k++) begin
          if (stage_q == STW'(k) && amt_q[k]) begin
            work_d = work_q << (1 << k);
          end
        end
        if (stage_q == LAST_STAGE) begin
          stage_d = '0;
          state_d = DONE;
        end else begin
          stage_d = stage_q + STW'(1);
        end
      end

      DONE: begin
        // Returning to IDLE (not straight to a new accept) is what makes
        // consume and accept impossible in the same cycle.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      amt_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      amt_q   <= amt_d;
      stage_q <= stage_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign data_out  = work_q;

endmodule
